// File: rtl/control_ifft_out_if.sv
// Bundle of the (I)FFT result port and the AXI-stream output port.
// master is the block's view, slave is the environment's view.
interface control_ifft_out_if #(
    parameter int PARATIL = 9,
    parameter int FFTCHNL = 8,
    parameter int DATALEN = 16
);
    logic                           ifftvalid;
    logic [FFTCHNL*2*DATALEN-1:0]   ifftdata [0:PARATIL-1];
    logic                           ifftready;
    logic                           axi_outvalid;
    logic                           axi_outready;
    logic                           axi_outlast;
    logic [63:0]                    axi_outdata;
    logic                           overflow;

    modport master (
        input  ifftvalid, ifftdata, axi_outready,
        output ifftready, axi_outvalid, axi_outlast, axi_outdata, overflow
    );

    modport slave (
        output ifftvalid, ifftdata, axi_outready,
        input  ifftready, axi_outvalid, axi_outlast, axi_outdata, overflow
    );
endinterface

// File: rtl/control_ifft_out.sv
// Captures one frame of 2D (I)FFT rows into a tile buffer, then
// streams it as 64-bit AXI beats (two complex samples per beat).
module control_ifft_out #(
    parameter int PARATIL = 9,
    parameter int FFTCHNL = 8,
    parameter int DATALEN = 16
) (
    input  logic clk,
    input  logic rstn,
    control_ifft_out_if.master io
);
    localparam int ROWS  = 64 / FFTCHNL;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int NBEAT = PARATIL * 32;
    localparam int BW    = $clog2(NBEAT);
    localparam int AW    = BW + 1;
    localparam int NSAMP = PARATIL * 64;
    localparam int SW    = 2 * DATALEN;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SEND    = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [RW-1:0]   row;
    logic [BW-1:0]   beat;
    logic            cap, load, done;
    logic [SW-1:0]   mem [NSAMP];

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    // Next state plus capture/load/finish strobes
    always_comb begin
        state_n = state;
        cap     = 1'b0;
        load    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                if (io.ifftvalid) begin
                    cap     = 1'b1;
                    state_n = (row == RW'(ROWS - 1)) ? SEND : COLLECT;
                end
            end
            SEND: begin
                if (!io.axi_outvalid) begin
                    load = 1'b1;
                end else if (io.axi_outready) begin
                    if (io.axi_outlast) begin
                        done    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Tile buffer write: lane t slice j (from MSB) is sample FFTCHNL*row+j
    always_ff @(posedge clk) begin
        if (cap) begin
            for (int t = 0; t < PARATIL; t++) begin
                for (int j = 0; j < FFTCHNL; j++) begin
                    mem[AW'(t*64 + FFTCHNL*int'(row) + j)] <=
                        io.ifftdata[t][(FFTCHNL-1-j)*SW +: SW];
                end
            end
        end
    end

    // Counters and registered outputs; beat b holds samples 2b and 2b+1
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row             <= '0;
            beat            <= '0;
            io.ifftready    <= 1'b1;
            io.axi_outvalid <= 1'b0;
            io.axi_outlast  <= 1'b0;
            io.axi_outdata  <= '0;
            io.overflow     <= 1'b0;
        end else begin
            io.ifftready <= (state_n != SEND);
            if (io.ifftvalid && !io.ifftready)
                io.overflow <= 1'b1;
            if (cap)
                row <= (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
            if (load) begin
                io.axi_outdata  <= {mem[{beat, 1'b1}], mem[{beat, 1'b0}]};
                io.axi_outlast  <= (beat == BW'(NBEAT - 1));
                io.axi_outvalid <= 1'b1;
                beat            <= beat + 1'b1;
            end
            if (done) begin
                io.axi_outvalid <= 1'b0;
                io.axi_outlast  <= 1'b0;
                beat            <= '0;
            end
        end
    end
endmodule

// File: tb/tb_control_ifft_out.sv
// Randomized bench for control_ifft_out with a frame-level
// reference model and an expected-beat scoreboard.
module tb_control_ifft_out;
    localparam int P  = 9;
    localparam int F  = 8;
    localparam int D  = 16;
    localparam int R  = 64 / F;
    localparam int NB = P * 32;

    logic clk;
    logic rstn;

    control_ifft_out_if #(.PARATIL(P), .FFTCHNL(F), .DATALEN(D)) bus ();

    control_ifft_out #(.PARATIL(P), .FFTCHNL(F), .DATALEN(D)) dut (
        .clk  (clk),
        .rstn (rstn),
        .io   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int nbeat   = 0;
    int nlast   = 0;
    int nb_frame = 0;
    bit rdy_rand = 0;

    logic [31:0] frame [P][64];
    logic [64:0] exp_q [$];

    task automatic chk(input string tag, input logic [64:0] got,
                       input logic [64:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // counting: each component = {tile[3:0], index[5:0]}
    task automatic gen_frame(input bit rnd);
        logic [15:0] c;
        for (int t = 0; t < P; t++)
            for (int i = 0; i < 64; i++) begin
                c = 16'(t*64 + i);
                frame[t][i] = rnd ? $urandom : {c, c};
            end
    endtask

    task automatic push_expected();
        int t, bb;
        for (int b = 0; b < NB; b++) begin
            t  = b / 32;
            bb = b % 32;
            exp_q.push_back({(b == NB-1), frame[t][2*bb+1], frame[t][2*bb]});
        end
    endtask

    // one clock; scores an accepted beat and checks stall stability
    task automatic step();
        logic pv, pr, pl;
        logic [63:0] pd;
        logic [64:0] e;
        pv = bus.axi_outvalid;
        pr = bus.axi_outready;
        pl = bus.axi_outlast;
        pd = bus.axi_outdata;
        @(posedge clk);
        #1;
        if (pv && pr) begin
            nbeat++;
            nb_frame++;
            if (pl) nlast++;
            if (exp_q.size() == 0) begin
                chk("extra_beat", {pl, pd}, 65'd0);
            end else begin
                e = exp_q.pop_front();
                chk("beat", {pl, pd}, e);
            end
        end else if (pv) begin
            chk("hold_valid", 65'(bus.axi_outvalid), 65'd1);
            chk("hold_data", {bus.axi_outlast, bus.axi_outdata}, {pl, pd});
        end
        bus.axi_outready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic drive_row(input int k);
        logic [F*32-1:0] r;
        for (int t = 0; t < P; t++) begin
            for (int j = 0; j < F; j++)
                r[(F-1-j)*32 +: 32] = frame[t][F*k + j];
            bus.ifftdata[t] = r;
        end
    endtask

    task automatic send_frame(input int gap_max);
        int g;
        nb_frame = 0;
        for (int k = 0; k < R; k++) begin
            bus.ifftvalid = 1'b0;
            g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            repeat (g) step();
            chk("rdy_row", 65'(bus.ifftready), 65'd1);
            bus.ifftvalid = 1'b1;
            drive_row(k);
            step();
        end
        bus.ifftvalid = 1'b0;
        push_expected();
        chk("rdy_drop", 65'(bus.ifftready), 65'd0);
    endtask

    task automatic check_reset_vals();
        chk("rst_ready", 65'(bus.ifftready), 65'd1);
        chk("rst_valid", 65'(bus.axi_outvalid), 65'd0);
        chk("rst_last", 65'(bus.axi_outlast), 65'd0);
        chk("rst_data", 65'(bus.axi_outdata), 65'd0);
        chk("rst_ovf", 65'(bus.overflow), 65'd0);
    endtask

    // run until the frame is drained and ifftready returns
    task automatic drain(input int budget, input int pulse_at,
                         input int rst_at, output int lat);
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            if (c == pulse_at) begin
                bus.ifftvalid = 1'b1;
                for (int t = 0; t < P; t++)
                    bus.ifftdata[t] = {F{$urandom}};
            end
            step();
            bus.ifftvalid = 1'b0;
            if (rst_at > 0 && nb_frame == rst_at) begin
                rstn = 1'b0;
                #1;
                check_reset_vals();
                exp_q.delete();
                @(negedge clk);
                rstn = 1'b1;
                lat = -2;
                return;
            end
            if (exp_q.size() == 0 && bus.ifftready) begin
                lat = c;
                return;
            end
        end
        chk("drain_timeout", 65'd1, 65'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, b0, l0;
        rstn = 1'b0;
        bus.ifftvalid = 1'b0;
        bus.axi_outready = 1'b1;
        for (int t = 0; t < P; t++) bus.ifftdata[t] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        @(negedge clk);
        rstn = 1'b1;

        // counting frame, back-to-back rows, no backpressure
        gen_frame(0);
        b0 = nbeat; l0 = nlast;
        send_frame(0);
        drain(400, 0, -1, lat);
        chk("lat289", 65'(lat), 65'd289);
        chk("beats1", 65'(nbeat - b0), 65'd288);
        chk("lasts1", 65'(nlast - l0), 65'd1);

        // same frame with random row gaps
        b0 = nbeat;
        send_frame(4);
        drain(400, 0, -1, lat);
        chk("lat_gap", 65'(lat), 65'd289);
        chk("beats2", 65'(nbeat - b0), 65'd288);

        // random data, random backpressure
        rdy_rand = 1;
        gen_frame(1);
        b0 = nbeat;
        send_frame(3);
        drain(3000, 0, -1, lat);
        chk("beats3", 65'(nbeat - b0), 65'd288);

        // overflow while sending
        rdy_rand = 0;
        gen_frame(0);
        send_frame(0);
        drain(400, 50, -1, lat);
        chk("ovf_set", 65'(bus.overflow), 65'd1);
        step(); step();
        chk("ovf_sticky", 65'(bus.overflow), 65'd1);
        rstn = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        rstn = 1'b1;

        // reset at beat 100, then a fresh frame
        rdy_rand = 1;
        gen_frame(1);
        send_frame(2);
        drain(3000, 0, 100, lat);
        chk("rst_mid", 65'(lat), -65'sd2);
        repeat (5) step();
        chk("no_stale", 65'(bus.axi_outvalid), 65'd0);
        gen_frame(1);
        b0 = nbeat;
        send_frame(2);
        drain(3000, 0, -1, lat);
        chk("beats4", 65'(nbeat - b0), 65'd288);

        // two frames, second row 0 as soon as ifftready rises
        rdy_rand = 0;
        b0 = nbeat; l0 = nlast;
        gen_frame(0);
        send_frame(0);
        drain(400, 0, -1, lat);
        gen_frame(1);
        send_frame(0);
        drain(400, 0, -1, lat);
        chk("beats_b2b", 65'(nbeat - b0), 65'd576);
        chk("lasts_b2b", 65'(nlast - l0), 65'd2);
        chk("ovf_b2b", 65'(bus.overflow), 65'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
